mem_port_arbiter: RTL

//  Shares one single-port unified memory between the CPU instruction-fetch port and data port.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch and data ports.
// Data wins by default; a streak counter lets a waiting fetch through after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_ready_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              gnt_inst_q, gnt_inst_d;
  logic              gnt_data_q, gnt_data_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inst_ready_q, inst_ready_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic              data_ready_q, data_ready_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      gnt_inst_q   <= 1'b0;
      gnt_data_q   <= 1'b0;
      streak_q     <= '0;
      cnt_q        <= '0;
      inst_ready_q <= 1'b0;
      inst_rdata_q <= '0;
      data_ready_q <= 1'b0;
      data_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_inst_q   <= gnt_inst_d;
      gnt_data_q   <= gnt_data_d;
      streak_q     <= streak_d;
      cnt_q        <= cnt_d;
      inst_ready_q <= inst_ready_d;
      inst_rdata_q <= inst_rdata_d;
      data_ready_q <= data_ready_d;
      data_rdata_q <= data_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    gnt_inst_d   = gnt_inst_q;
    gnt_data_d   = gnt_data_q;
    streak_d     = streak_q;
    cnt_d        = cnt_q;
    inst_ready_d = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_ready_d = 1'b0;
    data_rdata_d = data_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pick_data    = 1'b0;

    case (state_q)
      IDLE: begin
        if (inst_req_i || data_req_i) begin
          pick_data = data_req_i && !(inst_req_i && (streak_q == STK_MAX));
          state_d   = ISSUE;
          mem_en_d  = 1'b1;
          if (pick_data) begin
            gnt_data_d  = 1'b1;
            gnt_inst_d  = 1'b0;
            mem_we_d    = data_we_i;
            mem_addr_d  = data_addr_i;
            mem_wdata_d = data_wdata_i;
            if (!inst_req_i)               streak_d = '0;
            else if (streak_q != STK_MAX)  streak_d = streak_q + STK_W'(1);
          end else begin
            gnt_inst_d  = 1'b1;
            gnt_data_d  = 1'b0;
            mem_addr_d  = inst_addr_i;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (mem_we_q) begin
          state_d      = DONE;
          data_ready_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (gnt_data_q) begin
            data_ready_d = 1'b1;
            data_rdata_d = mem_rdata_i;
          end else begin
            inst_ready_d = 1'b1;
            inst_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign inst_ready_o = inst_ready_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_ready_o = data_ready_q;
  assign data_rdata_o = data_rdata_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;

endmodule
